// File: rtl/atm_pin_verifier.sv
// PIN-entry front end for the ATM controller: collects keypad digits, checks them
// against the card's reference PIN, enforces a key timeout and retains the card on lockout.
module atm_pin_verifier #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_W     = 4,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                cardIn,
  input  logic                                digit_valid,
  input  logic [DIGIT_W-1:0]                  digit,
  input  logic                                clear_key,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]       pin_ref,
  output logic                                correctPassword,
  output logic                                wrong_pin,
  output logic                                card_retained,
  output logic [$clog2(MAX_TRIES+1)-1:0]      tries_left,
  output logic [$clog2(NUM_DIGITS+1)-1:0]     entry_count
);

  localparam int TRIES_W = $clog2(MAX_TRIES + 1);
  localparam int CNT_W   = $clog2(NUM_DIGITS + 1);
  localparam int TMR_W   = $clog2(TIMEOUT_CYC);
  localparam int PIN_W   = NUM_DIGITS * DIGIT_W;

  localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(NUM_DIGITS - 1);
  localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TRIES_W-1:0] TRIES_MAX = TRIES_W'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    CHECK,
    GRANTED,
    LOCKED
  } state_t;

  state_t            state;
  logic              mismatch;
  logic [TMR_W-1:0]  timer;
  logic [DIGIT_W-1:0] ref_dig;
  logic              key_bad;

  // Digit 0 of the reference PIN lives in the most significant slice.
  function automatic logic [DIGIT_W-1:0] ref_digit(input logic [CNT_W-1:0] idx,
                                                   input logic [PIN_W-1:0] pin);
    logic [DIGIT_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == CNT_W'(i)) r = pin[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
    end
    return r;
  endfunction

  function automatic logic is_invalid_key(input logic [DIGIT_W-1:0] d);
    return 32'(d) > 32'd9;
  endfunction

  assign ref_dig = ref_digit(entry_count, pin_ref);
  assign key_bad = (digit != ref_dig) || is_invalid_key(digit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      correctPassword <= 1'b0;
      wrong_pin       <= 1'b0;
      card_retained   <= 1'b0;
      tries_left      <= TRIES_MAX;
      entry_count     <= '0;
      mismatch        <= 1'b0;
      timer           <= '0;
    end else begin
      wrong_pin <= 1'b0;
      // Card removal aborts everything silently, whatever the state.
      if (state != IDLE && !cardIn) begin
        state           <= IDLE;
        correctPassword <= 1'b0;
        card_retained   <= 1'b0;
        tries_left      <= TRIES_MAX;
        entry_count     <= '0;
        mismatch        <= 1'b0;
        timer           <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cardIn) begin
              state       <= COLLECT;
              entry_count <= '0;
              mismatch    <= 1'b0;
              timer       <= '0;
              tries_left  <= TRIES_MAX;
            end
          end
          COLLECT: begin
            if (clear_key) begin
              entry_count <= '0;
              mismatch    <= 1'b0;
              timer       <= '0;
            end else if (digit_valid) begin
              mismatch    <= mismatch | key_bad;
              entry_count <= entry_count + 1'b1;
              timer       <= '0;
              if (entry_count == LAST_IDX) state <= CHECK;
            end else if (timer == TMR_LAST) begin
              mismatch <= 1'b1;
              state    <= CHECK;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          CHECK: begin
            if (!mismatch) begin
              state           <= GRANTED;
              correctPassword <= 1'b1;
            end else begin
              wrong_pin   <= 1'b1;
              tries_left  <= tries_left - 1'b1;
              entry_count <= '0;
              mismatch    <= 1'b0;
              timer       <= '0;
              if (tries_left > TRIES_W'(1)) begin
                state <= COLLECT;
              end else begin
                state         <= LOCKED;
                card_retained <= 1'b1;
              end
            end
          end
          GRANTED: correctPassword <= 1'b1;
          LOCKED: begin
            card_retained   <= 1'b1;
            correctPassword <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atm_pin_verifier.sv
// Scoreboard bench for atm_pin_verifier: an attempt-level model predicts results,
// a negedge monitor compares them with what the DUT presents.
module tb_atm_pin_verifier;

  localparam int N    = 4;
  localparam int DW   = 4;
  localparam int MAXT = 3;
  localparam int TO   = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cardIn = 1'b0;
  logic          digit_valid = 1'b0;
  logic [DW-1:0] digit = '0;
  logic          clear_key = 1'b0;
  logic [N*DW-1:0] pin_ref = 16'h1234;
  logic          correctPassword, wrong_pin, card_retained;
  logic [1:0]    tries_left;
  logic [2:0]    entry_count;

  atm_pin_verifier #(.NUM_DIGITS(N), .DIGIT_W(DW), .MAX_TRIES(MAXT), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .cardIn(cardIn), .digit_valid(digit_valid), .digit(digit),
    .clear_key(clear_key), .pin_ref(pin_ref), .correctPassword(correctPassword),
    .wrong_pin(wrong_pin), .card_retained(card_retained), .tries_left(tries_left),
    .entry_count(entry_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_no  = 0;
  bit mon_en   = 0;

  // Reference model: session / attempt bookkeeping
  bit m_session = 0, m_granted = 0, m_locked = 0, m_pending = 0, m_ok = 0;
  int m_tries = MAXT;
  int m_idle  = 0;
  int m_keys[$];

  typedef struct { int kind; int at_edge; int tries; } ev_t;  // kind 0 pass, 1 fail, 2 lock
  ev_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  function automatic int pin_digit(input int i);
    return int'((pin_ref >> (DW * (N - 1 - i))) & 16'hF);
  endfunction

  function automatic bit attempt_matches();
    bit ok = 1;
    for (int i = 0; i < N; i++)
      if (m_keys[i] != pin_digit(i) || m_keys[i] > 9) ok = 0;
    return ok;
  endfunction

  function automatic void end_session();
    m_session = 0; m_granted = 0; m_locked = 0; m_pending = 0;
    m_keys.delete(); m_tries = MAXT; m_idle = 0;
  endfunction

  function automatic void model_step(input bit dv, input int d, input bit clr, input bit card);
    ev_t e;
    if (!m_session) begin
      if (card) begin
        m_session = 1; m_keys.delete(); m_idle = 0; m_tries = MAXT;
      end
      return;
    end
    if (!card) begin
      end_session();
      return;
    end
    if (m_pending) begin
      m_pending = 0;
      if (m_ok) begin
        m_granted = 1;
        e.kind = 0;
      end else begin
        m_tries--;
        m_keys.delete();
        m_idle = 0;
        if (m_tries == 0) m_locked = 1;
        e.kind = m_locked ? 2 : 1;
      end
      e.at_edge = edge_no;
      e.tries   = m_tries;
      exp_q.push_back(e);
      return;
    end
    if (m_granted || m_locked) return;
    if (clr) begin
      m_keys.delete(); m_idle = 0;
    end else if (dv) begin
      m_keys.push_back(d); m_idle = 0;
      if (m_keys.size() == N) begin
        m_pending = 1; m_ok = attempt_matches();
      end
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        m_pending = 1; m_ok = 0;
      end
    end
  endfunction

  task automatic tick(input bit dv, input logic [DW-1:0] d, input bit clr);
    digit_valid = dv; digit = d; clear_key = clr;
    @(posedge clk);
    edge_no++;
    model_step(dv, int'(d), clr, cardIn);
    #1;
    digit_valid = 1'b0; clear_key = 1'b0;
  endtask

  task automatic key(input int d);
    tick(1'b1, DW'(d), 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, '0, 1'b0);
  endtask

  task automatic insert_card();
    cardIn = 1'b1; idle(1);
  endtask

  task automatic remove_card();
    cardIn = 1'b0; idle(2);
  endtask

  // Monitor: level checks every cycle, result events popped from the scoreboard
  bit cp_prev = 0;
  initial begin
    int obs;
    bit rise;
    ev_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("correctPassword", correctPassword, m_granted);
        chk("card_retained", card_retained, m_locked);
        chk("tries_left", tries_left, m_tries);
        chk("entry_count", entry_count, m_keys.size());
        rise = correctPassword && !cp_prev;
        if (exp_q.size() > 0 && exp_q[0].at_edge < edge_no) begin
          e = exp_q.pop_front();
          n_checks++; n_fail++;
          $display("FAIL missed_result: kind %0d due at edge %0d never seen", e.kind, e.at_edge);
        end
        if (wrong_pin || rise) begin
          obs = rise ? 0 : (card_retained ? 2 : 1);
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_result: kind %0d at edge %0d, expected none", obs, edge_no);
          end else begin
            e = exp_q.pop_front();
            chk("result_kind", obs, e.kind);
            chk("result_edge", edge_no, e.at_edge);
            chk("result_tries", tries_left, e.tries);
          end
        end
      end
      cp_prev = correctPassword;
    end
  end

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cp"}, correctPassword, 0);
    chk({tag, "_wp"}, wrong_pin, 0);
    chk({tag, "_ret"}, card_retained, 0);
    chk({tag, "_tries"}, tries_left, MAXT);
    chk({tag, "_cnt"}, entry_count, 0);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 chk_reset_values("por");
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    mon_en = 1;
    @(posedge clk); #1;

    // correct PIN first time
    insert_card();
    key(1); key(2); key(3); key(4);
    idle(2);
    chk("t1_cp", correctPassword, 1);
    chk("t1_tries", tries_left, 3);
    key(5); clear_key = 1'b0; idle(1);
    chk("t1_hold", correctPassword, 1);
    remove_card();

    // one wrong attempt then correct
    insert_card();
    key(1); key(2); key(3); key(5);
    idle(1);
    chk("t2_tries", tries_left, 2);
    chk("t2_cnt", entry_count, 0);
    chk("t2_cp", correctPassword, 0);
    key(1); key(2); key(3); key(4);
    idle(2);
    chk("t2_cp_ok", correctPassword, 1);
    remove_card();

    // lockout after three failures
    insert_card();
    repeat (3) begin
      key(9); key(9); key(9); key(9); idle(1);
    end
    chk("t3_ret", card_retained, 1);
    chk("t3_tries", tries_left, 0);
    key(1); key(2); key(3); key(4); idle(2);
    chk("t3_cp", correctPassword, 0);
    cardIn = 1'b0; idle(1);
    chk("t3_release", card_retained, 0);
    idle(1);

    // clear_key handling
    insert_card();
    key(1); key(2); tick(1'b0, '0, 1'b1);
    key(1); key(2); key(3); key(4); idle(2);
    chk("t4_cp", correctPassword, 1);
    chk("t4_tries", tries_left, 3);
    remove_card();
    insert_card();
    key(1); tick(1'b1, 4'd2, 1'b1);
    chk("t4_both_cnt", entry_count, 0);
    key(1); key(2); key(3); key(4); idle(2);
    chk("t4_both_cp", correctPassword, 1);
    remove_card();

    // timeout and the key-in-last-cycle boundary
    insert_card();
    key(1); key(2); idle(TO); idle(1);
    chk("t5_tries", tries_left, 2);
    key(1); key(2); idle(TO - 1); key(3); key(4); idle(2);
    chk("t5_cp", correctPassword, 1);
    chk("t5_tries_keep", tries_left, 2);
    remove_card();

    // card removal and async reset mid-attempt
    insert_card();
    key(1); key(2);
    cardIn = 1'b0; idle(1);
    chk("t6_cnt", entry_count, 0);
    cardIn = 1'b1; idle(1);
    key(1); key(2); key(3);
    #2;
    mon_en = 0;
    reset = 1'b0;
    #1 chk_reset_values("async");
    end_session();
    @(negedge clk);
    reset = 1'b1;
    mon_en = 1;
    @(posedge clk); #1;
    remove_card();

    // randomized sessions
    for (int s = 0; s < 40; s++) begin
      for (int i = 0; i < N; i++) pin_ref[DW*i +: DW] = DW'($urandom_range(0, 9));
      insert_card();
      for (int st = 0; st < $urandom_range(30, 80); st++) begin
        int r;
        int d;
        r = $urandom_range(0, 99);
        if (r < 55) begin
          if ($urandom_range(0, 9) < 7 && m_keys.size() < N) d = pin_digit(m_keys.size());
          else d = $urandom_range(0, 15);
          key(d);
        end else if (r < 62) tick(1'b0, '0, 1'b1);
        else if (r < 66) tick(1'b1, DW'($urandom_range(0, 15)), 1'b1);
        else if (r < 92) idle(1);
        else idle($urandom_range(TO - 1, TO + 1));
      end
      remove_card();
    end

    idle(3);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/atm_pin_verifier.md
Name: atm_pin_verifier

Overview:
PIN-entry front end that drives the ATM controller's `correctPassword` input.
- Collects keypad digits once a card is inserted and compares them against the card's reference PIN.
- Counts failed attempts, enforces a key-entry timeout and retains the card after too many failures.
- Sits between the keypad/card-reader and the ATM controller FSM; it owns all PIN checking, so the controller only sees a clean pass/fail level.

Parameters:
NUM_DIGITS, 4, number of PIN digits per attempt (>=1)
DIGIT_W, 4, bits per keypad digit (BCD; values >9 are invalid keys)
MAX_TRIES, 3, failed attempts allowed before card retention (>=1)
TIMEOUT_CYC, 1000, idle cycles between keys before the attempt is failed (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cardIn  in  1  card present level from card reader
digit_valid  in  1  one-cycle strobe, digit is valid this cycle
digit  in  DIGIT_W  keypad digit value
clear_key  in  1  one-cycle strobe, discard digits of current attempt
pin_ref  in  NUM_DIGITS*DIGIT_W  reference PIN from card; digit 0 in MSBs; must be stable while cardIn=1
correctPassword  out  1  level, PIN accepted; to ATM controller
wrong_pin  out  1  one-cycle pulse per failed attempt
card_retained  out  1  level, tries exhausted, card held
tries_left  out  clog2(MAX_TRIES+1)  remaining attempts
entry_count  out  clog2(NUM_DIGITS+1)  digits entered in current attempt (display masking)

Behaviour:
- One clock domain; reset is asynchronous, active-low.
- All outputs are registered.
- Reset values:
  - state=IDLE
  - correctPassword=0, wrong_pin=0, card_retained=0
  - tries_left=MAX_TRIES
  - entry_count=0
  - internal mismatch flag=0, timer=0
- States: IDLE, COLLECT, CHECK, GRANTED, LOCKED.
- IDLE:
  - All outputs at reset values.
  - cardIn=1 sampled -> COLLECT with entry_count=0, mismatch=0, timer=0, tries_left=MAX_TRIES.
- COLLECT:
  - Accepted digit (digit_valid=1, clear_key=0):
    - Compare digit with pin_ref slice [entry_count].
    - mismatch |= (digit != slice) OR (digit > 9).
    - entry_count++, timer=0.
    - When the accepted digit is digit NUM_DIGITS-1 -> CHECK.
  - clear_key=1: entry_count=0, mismatch=0, timer=0; no attempt consumed.
  - clear_key and digit_valid in the same cycle: clear wins, digit dropped.
  - No key: timer++.
  - timer==TIMEOUT_CYC-1 with no key that cycle -> CHECK with mismatch forced to 1 (counts as a failure).
  - A key arriving in the timeout cycle wins and resets the timer.
- CHECK (exactly 1 cycle), then exactly one of:
  - mismatch=0 -> GRANTED, correctPassword=1.
  - mismatch=1 and tries_left>1:
    - wrong_pin=1 for one cycle.
    - tries_left-1; entry_count=0, mismatch=0, timer=0.
    - -> COLLECT.
  - mismatch=1 and tries_left==1:
    - wrong_pin pulse, tries_left=0, card_retained=1.
    - -> LOCKED.
- GRANTED:
  - correctPassword held 1.
  - digit_valid and clear_key are ignored.
  - Exit only on cardIn=0.
- LOCKED:
  - card_retained held 1, correctPassword=0.
  - Keys are ignored.
  - Exit only on cardIn=0.
- Card removal: cardIn=0 in any non-IDLE state -> IDLE on the next edge; all outputs return to reset values on that edge. This aborts any attempt in progress; no wrong_pin pulse.
- digit_valid outside COLLECT is ignored.
- entry_count never exceeds NUM_DIGITS-1 while in COLLECT.
- Latency:
  - Last digit sampled at edge k -> state CHECK after edge k.
  - correctPassword or wrong_pin registered after edge k+1.
  - Result is visible 2 cycles after the last key.
- Asynchronous reset mid-operation clears everything immediately, including card_retained.

Test Plan:
- pin_ref=16'h1234; cardIn=1; keys 1,2,3,4 -> correctPassword=1 exactly 2 cycles after key 4 and held; wrong_pin never pulses; tries_left=3.
- pin_ref=16'h1234; keys 1,2,3,5 -> one wrong_pin pulse, tries_left=2, entry_count=0, correctPassword=0; then keys 1,2,3,4 -> correctPassword=1.
- Three wrong attempts (e.g. 9,9,9,9 x3) -> tries_left 3->2->1->0, card_retained=1 after the 3rd; further correct keys leave correctPassword=0; cardIn=0 -> card_retained=0 next edge.
- Keys 1,2 then clear_key, then 1,2,3,4 -> accepted, tries_left=3. Also: clear_key and digit_valid in the same cycle -> entry_count=0, digit dropped.
- TIMEOUT_CYC=8; keys 1,2 then idle for 8 cycles -> wrong_pin pulse, tries_left=2. Also: a key arriving in the 8th idle cycle -> no timeout.
- Keys 1,2 then cardIn=0 -> IDLE next edge, no wrong_pin. Also: reset low mid-COLLECT -> all outputs at reset values immediately, without waiting for a clock edge.
